// File: rtl/fv_si_check_queue.sv
// -----------------------------------------------------------------------------
// fv_si_check_queue
//
// Single-instruction property checker with an in-order expectation queue.
// On every accepted issue the reference result of the instruction is computed
// combinationally and pushed at the queue tail with age 0. Every DUT
// register-file writeback pops the head and compares against it. Entries that
// wait too long are retired as timeouts. All error outputs are sticky and are
// intended as assertion targets in the formal harness.
//
// Optional feature: define FV_SI_CHECK_RV32M_EN to enable the M-extension
// multiply ops (13 MUL, 14 MULH, 15 MULHSU, 16 MULHU). Without it those codes
// are treated as illegal.
//
// Parameters:
//   XLEN    register width, 32 or 64
//   DEPTH   maximum outstanding checks (2..16)
//   MAX_LAT cycles an entry may wait before it times out (1..255)
//
// Ports:
//   clk, rst_n        clock (posedge) and synchronous active-low reset
//   flush             discard all pending entries
//   issue_valid/op/a/b/pc  instruction issued for checking
//   issue_ready       queue can accept an issue this cycle
//   wb_valid/wb_value DUT register-file writeback
//   pending           number of outstanding entries
//   pass_cnt          matched writebacks, saturating
//   err_*             sticky error flags
//   fail_exp/fail_act expected/actual values captured at the first mismatch
//
// Handshake: an issue is consumed on a posedge where issue_valid and
// issue_ready are both high; issue_ready depends only on registered state
// (pre-pop count) and rst_n, never on issue_valid. A writeback has no ready:
// it is consumed on every posedge where wb_valid is high.
// -----------------------------------------------------------------------------
module fv_si_check_queue #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 4,
    parameter int MAX_LAT = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       issue_valid,
    input  logic [4:0]                 issue_op,
    input  logic [XLEN-1:0]            issue_a,
    input  logic [XLEN-1:0]            issue_b,
    input  logic [XLEN-1:0]            issue_pc,
    output logic                       issue_ready,
    input  logic                       wb_valid,
    input  logic [XLEN-1:0]            wb_value,
    output logic [$clog2(DEPTH+1)-1:0] pending,
    output logic [31:0]                pass_cnt,
    output logic                       err_mismatch,
    output logic                       err_timeout,
    output logic                       err_spurious,
    output logic                       err_overflow,
    output logic                       err_illegal,
    output logic [XLEN-1:0]            fail_exp,
    output logic [XLEN-1:0]            fail_act
);

    localparam int SHW = (XLEN == 64) ? 6 : 5;
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(DEPTH + 1);
    localparam logic [7:0]    MAX_LAT_L = 8'(MAX_LAT);
    localparam logic [CW-1:0] DEPTH_L   = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_L    = PW'(DEPTH - 1);

    // Operation codes
    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLL    = 5'd2;
    localparam logic [4:0] OP_SLT    = 5'd3;
    localparam logic [4:0] OP_SLTU   = 5'd4;
    localparam logic [4:0] OP_XOR    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_OR     = 5'd8;
    localparam logic [4:0] OP_AND    = 5'd9;
    localparam logic [4:0] OP_PASSB  = 5'd10;
    localparam logic [4:0] OP_AUIPC  = 5'd11;
    localparam logic [4:0] OP_LINK   = 5'd12;
`ifdef FV_SI_CHECK_RV32M_EN
    localparam logic [4:0] OP_MUL    = 5'd13;
    localparam logic [4:0] OP_MULH   = 5'd14;
    localparam logic [4:0] OP_MULHSU = 5'd15;
    localparam logic [4:0] OP_MULHU  = 5'd16;
`endif

    // -------------------------------------------------------------------------
    // Queue storage and state
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] val_q [DEPTH];
    logic [7:0]      age_q [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     pass_q;
    logic            mism_q, tmo_q, spur_q, ovf_q, ill_q;
    logic [XLEN-1:0] fexp_q, fact_q;

    // -------------------------------------------------------------------------
    // Reference model of the instruction result
    // -------------------------------------------------------------------------
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] exp_val;
    logic            op_legal;

    assign shamt = issue_b[SHW-1:0];

`ifdef FV_SI_CHECK_RV32M_EN
    // Operands are extended to 2*XLEN according to signedness; the low 2*XLEN
    // bits of the product are then exact for every signedness combination.
    logic [2*XLEN-1:0] ext_a_s, ext_b_s, ext_a_u, ext_b_u;
    logic [2*XLEN-1:0] prod_ss, prod_su, prod_uu;

    assign ext_a_s = {{XLEN{issue_a[XLEN-1]}}, issue_a};
    assign ext_b_s = {{XLEN{issue_b[XLEN-1]}}, issue_b};
    assign ext_a_u = {{XLEN{1'b0}}, issue_a};
    assign ext_b_u = {{XLEN{1'b0}}, issue_b};
    assign prod_ss = ext_a_s * ext_b_s;
    assign prod_su = ext_a_s * ext_b_u;
    assign prod_uu = ext_a_u * ext_b_u;
`endif

    always_comb begin
        exp_val  = '0;
        op_legal = 1'b1;
        case (issue_op)
            OP_ADD:   exp_val = issue_a + issue_b;
            OP_SUB:   exp_val = issue_a - issue_b;
            OP_SLL:   exp_val = issue_a << shamt;
            OP_SLT:   exp_val = {{(XLEN-1){1'b0}}, ($signed(issue_a) < $signed(issue_b))};
            OP_SLTU:  exp_val = {{(XLEN-1){1'b0}}, (issue_a < issue_b)};
            OP_XOR:   exp_val = issue_a ^ issue_b;
            OP_SRL:   exp_val = issue_a >> shamt;
            OP_SRA:   exp_val = $unsigned($signed(issue_a) >>> shamt);
            OP_OR:    exp_val = issue_a | issue_b;
            OP_AND:   exp_val = issue_a & issue_b;
            OP_PASSB: exp_val = issue_b;
            OP_AUIPC: exp_val = issue_pc + issue_b;
            OP_LINK:  exp_val = issue_pc + XLEN'(4);
`ifdef FV_SI_CHECK_RV32M_EN
            OP_MUL:    exp_val = prod_uu[XLEN-1:0];
            OP_MULH:   exp_val = prod_ss[2*XLEN-1:XLEN];
            OP_MULHSU: exp_val = prod_su[2*XLEN-1:XLEN];
            OP_MULHU:  exp_val = prod_uu[2*XLEN-1:XLEN];
`endif
            default:  op_legal = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Control
    // -------------------------------------------------------------------------
    logic            eligible;   // at least one entry pushed on an earlier edge
    logic            accept;
    logic            wb_pop;
    logic            to_pop;
    logic            pop;
    logic [PW-1:0]   push_slot;
    logic [XLEN-1:0] head_val;
    logic [7:0]      head_age;

    // Entries in storage were all pushed on a previous edge, so a non-zero
    // registered count means the head is eligible; no same-cycle bypass.
    assign eligible    = (count_q != '0);
    assign issue_ready = rst_n && (count_q < DEPTH_L);
    assign accept      = issue_valid && issue_ready && op_legal;
    assign head_val    = val_q[head_q];
    assign head_age    = age_q[head_q];

    // Flush suppresses both writeback compare and timeout retirement.
    assign wb_pop = !flush && wb_valid && eligible;
    assign to_pop = !flush && !wb_valid && eligible && (head_age >= MAX_LAT_L);
    assign pop    = wb_pop || to_pop;

    // A flush empties the queue first, so a simultaneous issue lands in slot 0.
    assign push_slot = flush ? '0 : tail_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_L) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = accept ? ptr_inc('0) : '0;
            count_d = accept ? CW'(1) : '0;
        end else begin
            if (pop)    head_d = ptr_inc(head_q);
            if (accept) tail_d = ptr_inc(tail_q);
            case ({accept, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                val_q[i] <= '0;
                age_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            pass_q  <= '0;
            mism_q  <= 1'b0;
            tmo_q   <= 1'b0;
            spur_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
            fexp_q  <= '0;
            fact_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;

            // Every slot ages each cycle (empty slots are harmless since
            // a push overwrites the age); flush resets all ages.
            for (int i = 0; i < DEPTH; i++) begin
                if (flush)
                    age_q[i] <= '0;
                else if (age_q[i] != 8'hFF)
                    age_q[i] <= age_q[i] + 8'd1;
            end

            if (accept) begin
                val_q[push_slot] <= exp_val;
                age_q[push_slot] <= '0;
            end

            if (issue_valid && !issue_ready) ovf_q <= 1'b1;
            if (issue_valid && !op_legal)    ill_q <= 1'b1;

            if (!flush && wb_valid && !eligible) spur_q <= 1'b1;
            if (to_pop)                          tmo_q  <= 1'b1;

            if (wb_pop) begin
                if (wb_value == head_val) begin
                    if (pass_q != 32'hFFFF_FFFF) pass_q <= pass_q + 32'd1;
                end else begin
                    mism_q <= 1'b1;
                    if (!mism_q) begin
                        fexp_q <= head_val;
                        fact_q <= wb_value;
                    end
                end
            end
        end
    end

    assign pending      = count_q;
    assign pass_cnt     = pass_q;
    assign err_mismatch = mism_q;
    assign err_timeout  = tmo_q;
    assign err_spurious = spur_q;
    assign err_overflow = ovf_q;
    assign err_illegal  = ill_q;
    assign fail_exp     = fexp_q;
    assign fail_act     = fact_q;

endmodule

// File: tb/tb_fv_si_check_queue.sv
module tb_fv_si_check_queue;
  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  localparam int MAX_LAT = 16;
  localparam int CW = $clog2(DEPTH + 1);

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic            flush, issue_valid, wb_valid, issue_ready;
  logic [4:0]      issue_op;
  logic [XLEN-1:0] issue_a, issue_b, issue_pc, wb_value, fail_exp, fail_act;
  logic [CW-1:0]   pending;
  logic [31:0]     pass_cnt;
  logic            err_mismatch, err_timeout, err_spurious, err_overflow, err_illegal;

  fv_si_check_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_LAT(MAX_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_a(issue_a),
    .issue_b(issue_b), .issue_pc(issue_pc), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_value(wb_value), .pending(pending),
    .pass_cnt(pass_cnt), .err_mismatch(err_mismatch), .err_timeout(err_timeout),
    .err_spurious(err_spurious), .err_overflow(err_overflow),
    .err_illegal(err_illegal), .fail_exp(fail_exp), .fail_act(fail_act)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // inputs change 1 time unit after the active edge; outputs sampled there too
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0; issue_valid = 1'b0; issue_op = '0; issue_a = '0;
    issue_b = '0; issue_pc = '0; wb_valid = 1'b0; wb_value = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_issue(input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] pc);
    issue_valid = 1'b1; issue_op = op; issue_a = a; issue_b = b; issue_pc = pc;
  endtask

  task automatic set_wb(input logic [31:0] v);
    wb_valid = 1'b1; wb_value = v;
  endtask

  task automatic chk_errs(input string tag, input logic [4:0] exp);
    chk(tag, {err_mismatch, err_timeout, err_spurious, err_overflow, err_illegal}, exp);
  endtask

  // op table: op, a, b, pc, expected result
  logic [4:0]  t_op [11];
  logic [31:0] t_a [11], t_b [11], t_pc [11], t_exp [11];

  int to_t;
  logic [CW-1:0] to_pend;

  initial begin
    t_op[0]  = 5'd0;  t_a[0]  = 32'hFFFF_FFFF; t_b[0]  = 32'h2;         t_pc[0]  = 0;          t_exp[0]  = 32'h1;
    t_op[1]  = 5'd1;  t_a[1]  = 32'd5;         t_b[1]  = 32'd7;         t_pc[1]  = 0;          t_exp[1]  = 32'hFFFF_FFFE;
    t_op[2]  = 5'd2;  t_a[2]  = 32'h1;         t_b[2]  = 32'h21;        t_pc[2]  = 0;          t_exp[2]  = 32'h2;
    t_op[3]  = 5'd3;  t_a[3]  = 32'hFFFF_FFFF; t_b[3]  = 32'h1;         t_pc[3]  = 0;          t_exp[3]  = 32'h1;
    t_op[4]  = 5'd4;  t_a[4]  = 32'hFFFF_FFFF; t_b[4]  = 32'h1;         t_pc[4]  = 0;          t_exp[4]  = 32'h0;
    t_op[5]  = 5'd5;  t_a[5]  = 32'hF0F0_F0F0; t_b[5]  = 32'hFF00_FF00; t_pc[5]  = 0;          t_exp[5]  = 32'h0FF0_0FF0;
    t_op[6]  = 5'd6;  t_a[6]  = 32'h8000_0000; t_b[6]  = 32'h4;         t_pc[6]  = 0;          t_exp[6]  = 32'h0800_0000;
    t_op[7]  = 5'd8;  t_a[7]  = 32'hF0F0_F0F0; t_b[7]  = 32'h0F00_0000; t_pc[7]  = 0;          t_exp[7]  = 32'hFFF0_F0F0;
    t_op[8]  = 5'd9;  t_a[8]  = 32'hF0F0_F0F0; t_b[8]  = 32'hFF00_FF00; t_pc[8]  = 0;          t_exp[8]  = 32'hF000_F000;
    t_op[9]  = 5'd10; t_a[9]  = 32'h0;         t_b[9]  = 32'h1234_5000; t_pc[9]  = 0;          t_exp[9]  = 32'h1234_5000;
    t_op[10] = 5'd11; t_a[10] = 32'h0;         t_b[10] = 32'h2000;      t_pc[10] = 32'h1000;   t_exp[10] = 32'h3000;

    // ---- reset state ----
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_ready", issue_ready, 0);
    chk("rst_pending", pending, 0);
    chk("rst_pass", pass_cnt, 0);
    chk_errs("rst_errs", 5'b0);
    chk("rst_fexp", fail_exp, 0);
    chk("rst_fact", fail_act, 0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", issue_ready, 1);

    // ---- ADD 7+5, wb 12 at cycle 3 ----
    set_issue(5'd0, 32'd7, 32'd5, 32'd0);
    tick(); idle();
    chk("add_pending1", pending, 1);
    tick(); tick();
    set_wb(32'd12);
    tick(); idle();
    chk("add_pass", pass_cnt, 1);
    chk("add_pending0", pending, 0);
    chk_errs("add_errs", 5'b0);

    // ---- SRA then SLTU, second writeback wrong ----
    do_reset();
    set_issue(5'd7, 32'h8000_0000, 32'd4, 32'd0);
    tick();
    set_issue(5'd4, 32'd1, 32'hFFFF_FFFF, 32'd0);
    tick(); idle();
    chk("sra_pending2", pending, 2);
    set_wb(32'hF800_0000);
    tick();
    set_wb(32'h0);
    tick(); idle();
    chk("mm_flag", err_mismatch, 1);
    chk("mm_fexp", fail_exp, 32'h1);
    chk("mm_fact", fail_act, 32'h0);
    chk("mm_pass", pass_cnt, 1);
    chk("mm_pending", pending, 0);

    // ---- overflow and timeout ----
    do_reset();
    chk("rst_clears_mm", err_mismatch, 0);
    for (int k = 0; k < 4; k++) begin
      set_issue(5'd0, 32'(k), 32'd1, 32'd0);
      tick();
    end
    idle();
    chk("full_pending", pending, 4);
    chk("full_ready", issue_ready, 0);
    set_issue(5'd0, 32'd9, 32'd1, 32'd0);
    tick(); idle();
    chk("ovf_flag", err_overflow, 1);
    chk("ovf_pending", pending, 4);
    to_t = -1;
    to_pend = '0;
    for (int k = 5; k <= 40; k++) begin
      tick();
      if (err_timeout && to_t < 0) begin
        to_t = k;
        to_pend = pending;
      end
    end
    chk("to_cycle", 64'(to_t), 64'd17);
    chk("to_pending", to_pend, 3);

    // ---- spurious writeback on first issue cycle ----
    do_reset();
    set_issue(5'd0, 32'd7, 32'd5, 32'd0);
    set_wb(32'd12);
    tick(); idle();
    chk("spur_flag", err_spurious, 1);
    chk("spur_pending", pending, 1);
    chk("spur_pass", pass_cnt, 0);
    set_wb(32'd12);
    tick(); idle();
    chk("spur_then_pass", pass_cnt, 1);

    // ---- LINK x2, flush with writeback ----
    do_reset();
    set_issue(5'd12, 32'd0, 32'd0, 32'h100);
    tick();
    tick(); idle();
    chk("link_pending", pending, 2);
    flush = 1'b1;
    set_wb(32'h104);
    tick(); idle();
    chk("flush_pending", pending, 0);
    chk_errs("flush_errs", 5'b0);
    chk("flush_pass", pass_cnt, 0);
    set_wb(32'h104);
    tick(); idle();
    chk("post_flush_spur", err_spurious, 1);
    // flush with simultaneous issue keeps the new entry
    set_issue(5'd12, 32'd0, 32'd0, 32'h100);
    tick();
    flush = 1'b1;
    set_issue(5'd12, 32'd0, 32'd0, 32'h200);
    tick(); idle();
    chk("flush_issue_pending", pending, 1);
    set_wb(32'h204);
    tick(); idle();
    chk("flush_issue_pass", pass_cnt, 1);
    chk("flush_issue_mm", err_mismatch, 0);

    // ---- op table ----
    do_reset();
    for (int i = 0; i < 11; i++) begin
      set_issue(t_op[i], t_a[i], t_b[i], t_pc[i]);
      tick(); idle();
      set_wb(t_exp[i]);
      tick(); idle();
      chk($sformatf("op%0d_pass", t_op[i]), pass_cnt, 64'(i + 1));
    end
    chk_errs("ops_errs", 5'b0);

    // ---- optional multiply ----
    do_reset();
`ifdef FV_SI_CHECK_RV32M_EN
    set_issue(5'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    tick(); idle();
    set_wb(32'hFFFF_FFFE);
    tick(); idle();
    chk("mulhu_pass", pass_cnt, 1);
    chk_errs("mulhu_errs", 5'b0);
`else
    set_issue(5'd13, 32'd3, 32'd4, 32'd0);
    tick(); idle();
    chk("op13_illegal", err_illegal, 1);
    chk("op13_pending", pending, 0);
`endif
    set_issue(5'd31, 32'd3, 32'd4, 32'd0);
    tick(); idle();
    chk("op31_illegal", err_illegal, 1);
    chk("op31_pending", pending, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
